// File: rtl/counter_sequencer_pkg.sv
// Shared encodings for the command-driven counter sequencer.
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_sequencer_core.sv
// Counter datapath: load, single up/down step and boundary detection.
// With COUNTER_SEQUENCER_SAT_EN defined the counter saturates instead of wrapping.
module counter_sequencer_core #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] count,
  output logic             bound
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;

  // High when a step in the current direction would cross the range edge.
  assign bound = dir ? (count_q == '1) : (count_q == '0);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (ld) begin
      count_d = ld_val;
    end else if (en) begin
`ifdef COUNTER_SEQUENCER_SAT_EN
      if (!bound) begin
        count_d = dir ? (count_q + One) : (count_q - One);
      end
`else
      count_d = dir ? (count_q + One) : (count_q - One);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Sequenced up/down counter: accepts LOAD/UP/DOWN/NOP commands and steps one count per clock.
// Optional saturation instead of wrap is selected by COUNTER_SEQUENCER_SAT_EN.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned STEPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [STEPW-1:0] cmd_arg,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [STEPW-1:0] RemOne = STEPW'(1);

  state_e           state_q, state_d;
  logic [STEPW-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             done_q, wrap_q;
  logic             accept, step_en, load_en, bound;
  op_e              op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE) && rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign wrap      = wrap_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    step_en = 1'b0;
    load_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (op)
            OP_LOAD: begin
              load_en = 1'b1;
              state_d = ST_DONE;
            end
            OP_NOP: state_d = ST_DONE;
            OP_UP, OP_DOWN: begin
              if (cmd_arg == '0) begin
                state_d = ST_DONE;
              end else begin
                rem_d   = cmd_arg;
                dir_d   = (op == OP_UP);
                state_d = ST_RUN;
              end
            end
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_RUN: begin
        // Pause freezes both the counter and the remaining-step count.
        if (!pause) begin
          step_en = 1'b1;
          rem_d   = rem_q - RemOne;
          if (rem_q == RemOne) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= (state_d == ST_DONE);
      wrap_q  <= step_en && bound;
    end
  end

  counter_sequencer_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .en     (step_en),
    .dir    (dir_q),
    .ld     (load_en),
    .ld_val (cmd_arg[WIDTH-1:0]),
    .count  (count),
    .bound  (bound)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: behavioural model plus directed literal checks.
module tb_counter_sequencer;

  localparam int W    = 3;
  localparam int S    = 4;
  localparam int MAXV = 7;
`ifdef COUNTER_SEQUENCER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         pause = 1'b0;
  logic [1:0]   cmd_op = 2'b00;
  logic [S-1:0] cmd_arg = '0;
  logic         cmd_ready, busy, done, wrap;
  logic [W-1:0] count;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Model: count value, steps still to take, and a completion/wrap flag per cycle.
  int m_count = 0;
  int m_left = 0;
  bit m_dir = 1'b0;
  bit m_done = 1'b0;
  bit m_wrap = 1'b0;
  bit nd, nw;

  always #5 clk = ~clk;

  counter_sequencer #(
    .WIDTH (W),
    .STEPW (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .pause     (pause),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    nd = 1'b0;
    nw = 1'b0;
    if (!rst) begin
      m_count = 0;
      m_left  = 0;
    end else if (m_done) begin
      // completion cycle: returns to idle
    end else if (m_left > 0) begin
      if (!pause) begin
        if (m_dir) begin
          if (m_count == MAXV) begin
            nw = 1'b1;
            if (!SAT) m_count = 0;
          end else m_count = m_count + 1;
        end else begin
          if (m_count == 0) begin
            nw = 1'b1;
            if (!SAT) m_count = MAXV;
          end else m_count = m_count - 1;
        end
        m_left = m_left - 1;
        nd = (m_left == 0);
      end
    end else if (cmd_valid) begin
      case (cmd_op)
        2'd3: begin
          m_count = int'(cmd_arg) % (MAXV + 1);
          nd = 1'b1;
        end
        2'd0: nd = 1'b1;
        default: begin
          if (cmd_arg == 0) nd = 1'b1;
          else begin
            m_left = int'(cmd_arg);
            m_dir  = (cmd_op == 2'd1);
          end
        end
      endcase
    end
    m_done = nd;
    m_wrap = nw;
  end

  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      check("model_count", count, m_count);
      check("model_busy", busy, (m_left > 0) || m_done);
      check("model_done", done, m_done);
      check("model_wrap", wrap, m_wrap);
      check("model_ready", cmd_ready, rst && !((m_left > 0) || m_done));
    end
  end

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic issue(input logic [1:0] op, input int arg);
    int i;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = S'(arg);
    i = 0;
    while (i < 100) begin
      #1;
      if (cmd_ready) break;
      @(negedge clk);
      i++;
    end
    check("accept_in_time", i < 100, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_arg   = S'($urandom);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (i < 100) begin
      #1;
      if (!busy) break;
      @(negedge clk);
      i++;
    end
    check("idle_in_time", i < 100, 1);
    @(negedge clk);
  endtask

  int ec[8], ew[8], edn[8], eb[8];
  int c4, c6;

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready_low", cmd_ready, 0);
    cmp_en = 1'b1;
    rst = 1'b1;
    #0.5;
    check("ready_after_release", cmd_ready, 1);
    @(negedge clk);

    // Reset aborts an active UP 5
    issue(2'd1, 5);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("abort_count", count, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ready", cmd_ready, 0);
    rst = 1'b1;
    @(negedge clk);

    // LOAD 5 then UP 4
    issue(2'd3, 5);
    wait_idle();
    issue(2'd1, 4);
    ec  = '{5, 6, 7, 0, 1, 0, 0, 0};
    ew  = '{0, 0, 0, 1, 0, 0, 0, 0};
    if (SAT) begin
      ec = '{5, 6, 7, 7, 7, 0, 0, 0};
      ew = '{0, 0, 0, 1, 1, 0, 0, 0};
    end
    edn = '{0, 0, 0, 0, 1, 0, 0, 0};
    for (int k = 0; k < 5; k++) begin
      #1;
      check("up4_count", count, ec[k]);
      check("up4_wrap", wrap, ew[k]);
      check("up4_done", done, edn[k]);
      check("up4_ready", cmd_ready, 0);
      @(negedge clk);
    end
    #1;
    check("up4_ready_after", cmd_ready, 1);
    @(negedge clk);

    // DOWN 3 from 1 with a 2-cycle pause after the first step
    issue(2'd3, 1);
    wait_idle();
    issue(2'd2, 3);
    ec  = '{1, 0, 0, 0, 7, 6, 6, 0};
    if (SAT) ec = '{1, 0, 0, 0, 0, 0, 0, 0};
    ew  = '{0, 0, 0, 0, 1, 0, 0, 0};
    edn = '{0, 0, 0, 0, 0, 1, 0, 0};
    eb  = '{1, 1, 1, 1, 1, 1, 0, 0};
    for (int k = 0; k < 7; k++) begin
      #1;
      check("down3_count", count, ec[k]);
      check("down3_wrap", wrap, ew[k]);
      check("down3_done", done, edn[k]);
      check("down3_busy", busy, eb[k]);
      if (k == 1) pause = 1'b1;
      if (k == 3) pause = 1'b0;
      @(negedge clk);
    end

    // UP 0 and NOP complete in one cycle
    c4 = SAT ? 0 : 6;
    for (int j = 0; j < 2; j++) begin
      issue((j == 0) ? 2'd1 : 2'd0, 0);
      #1;
      check("zero_done", done, 1);
      check("zero_busy", busy, 1);
      check("zero_count", count, c4);
      @(negedge clk);
      #1;
      check("zero_done_end", done, 0);
      check("zero_busy_end", busy, 0);
      @(negedge clk);
    end

    // cmd_valid held high while busy with changing ops
    c6 = SAT ? 2 : 0;
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_arg   = 4'd2;
    eb = '{1, 0, 0, 0, 1, 0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      #1;
      check("hold_ready", cmd_ready, eb[k]);
      if (k == 3) begin
        check("hold_up_count", count, c6);
        check("hold_up_done", done, 1);
      end
      if (k == 5) begin
        check("hold_load_count", count, 3);
        check("hold_load_done", done, 1);
        cmd_valid = 1'b0;
      end
      if (k == 1 || k == 3) begin
        cmd_op  = 2'd3;
        cmd_arg = 4'd3;
      end
      if (k == 2) cmd_op = 2'd0;
      @(negedge clk);
    end
    wait_idle();

    // LOAD 6, UP 3: wraps once, or saturates twice
    issue(2'd3, 6);
    wait_idle();
    issue(2'd1, 3);
    ec  = '{6, 7, 0, 1, 0, 0, 0, 0};
    ew  = '{0, 0, 1, 0, 0, 0, 0, 0};
    if (SAT) begin
      ec = '{6, 7, 7, 7, 0, 0, 0, 0};
      ew = '{0, 0, 1, 1, 0, 0, 0, 0};
    end
    edn = '{0, 0, 0, 1, 0, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      #1;
      check("up3_count", count, ec[k]);
      check("up3_wrap", wrap, ew[k]);
      check("up3_done", done, edn[k]);
      @(negedge clk);
    end
    wait_idle();

    // Randomized traffic checked by the model
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(0, 63) != 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 2'($urandom);
      cmd_arg   = ($urandom_range(0, 3) == 0) ? S'($urandom) : S'($urandom_range(0, 3));
      pause     = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    rst       = 1'b1;
    cmd_valid = 1'b0;
    pause     = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
